swap_arbiter: RTL and testbench
===============================

# swap_arbiter

Shares a single byte nibble-swap datapath (out = {in[3:0], in[7:4]}) between NREQ requesters. Arbitration is round-robin, with one registered output stage and a valid/ready handshake on every side. It sits between the requester byte streams and the single downstream consumer of swapped bytes. It also keeps a running count of completed swaps for debug readout.

## Interface
- NREQ, 4: number of requesters; legal range 2..8.
- IDW, 3: width of the requester id; must satisfy 2**IDW >= NREQ.
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- req_valid  input  NREQ  bit i: requester i presents a byte.
- req_data  input  8*NREQ  byte i at [8*i+7:8*i].
- req_ready  output  NREQ  bit i: byte i is accepted this cycle; at most one bit set (one-hot or zero).
- out_valid  output  1  out_data and out_id are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_data  output  8  nibble-swapped byte.
- out_id  output  IDW  index of the requester that supplied out_data.
- swap_count  output  16  number of completed output transfers; wraps modulo 2**16.

## Operation
- Output stage: a one-entry register holding out_valid, out_data and out_id.
- load = !out_valid || out_ready. The register can take a new byte when empty or draining.
- Arbitration happens only when load=1. The grant goes to the first i with req_valid[i], scanning from (last+1) mod NREQ upward with wrap.
- req_ready[i] = load && grant==i. It depends combinationally on req_valid and out_ready. Requesters must not make req_valid depend on req_ready.
- On a transfer (req_valid[g] && req_ready[g]):
  - out_data <= {req_data[g][3:0], req_data[g][7:4]}
  - out_id <= g
  - out_valid <= 1
  - last <= g
- When load=1 and no requester is valid: out_valid <= 0. out_data and out_id hold their old values (don't-care).
- last updates only on a transfer. Idle cycles do not rotate priority.
- Stall: when out_valid=1 and out_ready=0, all of the following hold:
  - req_ready = 0.
  - The output register holds.
  - last holds.
- swap_count increments by 1 on each cycle with out_valid && out_ready. It wraps from 0xFFFF to 0x0000.
- Simultaneous drain and fill (out_valid=1, out_ready=1, a requester valid): the new byte loads in the same cycle. There is no bubble.
- Requester i with req_valid held high waits at most NREQ-1 transfers before it is granted.
- Requester index >= NREQ cannot occur. last is kept in the range 0..NREQ-1.

## Timing
- Reset values:
  - out_valid=0, out_data=8'h00, out_id=0, swap_count=0.
  - last=NREQ-1, so requester 0 has first priority after reset.
  - req_ready=0 during any cycle with reset=1.
- Reset asserted mid-operation discards the held output byte. No transfer completes on that edge, and swap_count does not increment on that edge.
- Latency: a byte accepted at edge n appears on out_data with out_valid=1 after edge n. Latency is 1 cycle.
- Throughput: 1 byte per cycle while out_ready=1 and any requester is valid.
- Outputs are registered except req_ready.

## Test plan
- Reset, then req_valid=4'b0001, req_data[7:0]=8'hA5, out_ready=1 -> req_ready=4'b0001. The next cycle shows out_valid=1, out_data=8'h5A, out_id=0. swap_count=1 one cycle later.
- All four valid continuously with bytes 8'h12, 8'h34, 8'h56, 8'h78, out_ready=1 -> out_id sequence 0,1,2,3,0,1,… with out_data 8'h21, 8'h43, 8'h65, 8'h87 repeating. No idle cycles.
- Requester 2 valid (8'hF0), out_ready held 0 for 3 cycles -> out_data=8'h0F, out_id=2 stable. req_ready=0 throughout the stall. swap_count unchanged until out_ready=1.
- Requesters 1 and 3 valid after a grant to 3 -> the next grant is 1. Priority resumes from last+1 with wrap, with no starvation.
- Preload swap_count near wrap by running 65537 transfers -> swap_count reads 0xFFFF and then 0x0001 at the corresponding points.
- Assert reset while out_valid=1 and out_ready=0 -> the next cycle has out_valid=0 and swap_count=0. The first grant after release goes to requester 0.

Source files
------------

// File: rtl/swap_arbiter.sv
// swap_arbiter: round-robin arbiter in front of one registered nibble-swap stage (valid/ready on both sides, debug swap counter)
`timescale 1ns/1ps
module swap_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [IDW-1:0]    out_id,
  output logic [15:0]       swap_count
);
  logic [IDW-1:0] last, grant;
  logic any, load;
  logic [7:0] sel;
  assign load = !out_valid || out_ready;
  always_comb begin
    int idx;
    idx = 0;
    grant = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(last) + 1 + k) % NREQ;
      if (req_valid[idx]) begin
        grant = IDW'(idx);
        any = 1'b1;
      end
    end
  end
  assign sel = req_data[8*grant +: 8];
  assign req_ready = (load && any && !reset) ? (NREQ'(1) << grant) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= 8'h00;
      out_id <= '0;
      swap_count <= 16'h0000;
      last <= IDW'(NREQ - 1);
    end else begin
      if (out_valid && out_ready) swap_count <= swap_count + 16'd1;
      if (load) begin
        out_valid <= any;
        if (any) begin
          out_data <= {sel[3:0], sel[7:4]};
          out_id <= grant;
          last <= grant;
        end
      end
    end
  end
endmodule

// File: tb/tb_swap_arbiter.sv
// tb_swap_arbiter: directed self-checking bench for swap_arbiter
`timescale 1ns/1ps
module tb_swap_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] out_id;
  logic [15:0] swap_count;
  int checks = 0;
  int errors = 0;
  swap_arbiter #(.NREQ(4), .IDW(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .swap_count(swap_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'hF;
    out_ready = 1'b1;
    step();
    step();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (out_id !== 3'd0) begin errors++; $display("FAIL reset_out_id got %0d want 0", out_id); end
    checks++; if (swap_count !== 16'h0000) begin errors++; $display("FAIL reset_swap_count got %h want 0000", swap_count); end
    req_valid = '0;
    reset = 1'b0;
    #1;
  endtask
  task automatic test_single();
    req_data = 32'h000000A5;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL single_out_data got %h want 5a", out_data); end
    checks++; if (out_id !== 3'd0) begin errors++; $display("FAIL single_out_id got %0d want 0", out_id); end
    checks++; if (swap_count !== 16'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", swap_count); end
    step();
    checks++; if (swap_count !== 16'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", swap_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", out_valid); end
  endtask
  task automatic test_round_robin();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h21; exp_data[1] = 8'h43; exp_data[2] = 8'h65; exp_data[3] = 8'h87;
    do_reset();
    req_data = 32'h78563412;
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_req_ready[%0d] got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
      step();
      checks++; if (out_valid !== 1'b1 || out_id !== 3'(k % 4) || out_data !== exp_data[k % 4]) begin errors++; $display("FAIL rr_out[%0d] got v%b id%0d %h want v1 id%0d %h", k, out_valid, out_id, out_data, k % 4, exp_data[k % 4]); end
    end
    req_valid = '0;
    step();
    checks++; if (swap_count !== 16'd8 || out_valid !== 1'b0) begin errors++; $display("FAIL rr_count got %0d v%b want 8 v0", swap_count, out_valid); end
  endtask
  task automatic test_stall();
    req_data = 32'h00F00000;
    req_valid = 4'b0100;
    out_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_fill_ready got %b want 0100", req_ready); end
    step();
    req_data = 32'h00F000A5;
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0000", k, req_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h0F || out_id !== 3'd2) begin errors++; $display("FAIL stall_hold[%0d] got v%b %h id%0d want v1 0f id2", k, out_valid, out_data, out_id); end
      checks++; if (swap_count !== 16'd8) begin errors++; $display("FAIL stall_count[%0d] got %0d want 8", k, swap_count); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_release_ready got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    checks++; if (swap_count !== 16'd9 || out_id !== 3'd0 || out_data !== 8'h5A) begin errors++; $display("FAIL stall_drain got c%0d id%0d %h want c9 id0 5a", swap_count, out_id, out_data); end
    step();
    checks++; if (swap_count !== 16'd10 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_end got c%0d v%b want c10 v0", swap_count, out_valid); end
  endtask
  task automatic test_priority();
    req_data = 32'h78563412;
    req_valid = 4'b1000;
    out_ready = 1'b1;
    step();
    checks++; if (out_id !== 3'd3 || out_data !== 8'h87) begin errors++; $display("FAIL prio_first got id%0d %h want id3 87", out_id, out_data); end
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL prio_wrap_ready got %b want 0010", req_ready); end
    step();
    checks++; if (out_id !== 3'd1 || out_data !== 8'h43) begin errors++; $display("FAIL prio_second got id%0d %h want id1 43", out_id, out_data); end
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL prio_next_ready got %b want 1000", req_ready); end
    step();
    checks++; if (out_id !== 3'd3 || out_data !== 8'h87) begin errors++; $display("FAIL prio_third got id%0d %h want id3 87", out_id, out_data); end
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL prio_again_ready got %b want 0010", req_ready); end
    req_valid = '0;
    step();
    checks++; if (swap_count !== 16'd13 || out_valid !== 1'b0) begin errors++; $display("FAIL prio_count got c%0d v%b want c13 v0", swap_count, out_valid); end
  endtask
  task automatic test_wrap();
    do_reset();
    req_data = 32'h000000C3;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    repeat (65536) step();
    checks++; if (swap_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h want ffff", swap_count); end
    step();
    checks++; if (swap_count !== 16'h0000) begin errors++; $display("FAIL wrap_0000 got %h want 0000", swap_count); end
    step();
    checks++; if (swap_count !== 16'h0001) begin errors++; $display("FAIL wrap_0001 got %h want 0001", swap_count); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin errors++; $display("FAIL wrap_out got v%b %h want v1 3c", out_valid, out_data); end
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b0;
    req_valid = '0;
    step();
    checks++; if (out_valid !== 1'b1 || swap_count !== 16'h0001) begin errors++; $display("FAIL mid_pre got v%b c%0d want v1 c1", out_valid, swap_count); end
    reset = 1'b1;
    out_ready = 1'b1;
    req_data = 32'h00F000A5;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready got %b want 0000", req_ready); end
    step();
    reset = 1'b0;
    req_valid = 4'b0101;
    #1;
    checks++; if (out_valid !== 1'b0 || swap_count !== 16'h0000) begin errors++; $display("FAIL mid_cleared got v%b c%0d want v0 c0", out_valid, swap_count); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    checks++; if (out_valid !== 1'b1 || out_id !== 3'd0 || out_data !== 8'h5A) begin errors++; $display("FAIL mid_out got v%b id%0d %h want v1 id0 5a", out_valid, out_id, out_data); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_priority();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
